// File: rtl/mcs4_ram_bus_master.sv
// Host-driven MCS-4 bus sequencer: free-running 8-clock instruction cycle with sync,
// turning one valid/ready request into SRC, I/O-command and readback cycles for i4002 RAMs.
module mcs4_ram_bus_master #(
  parameter bit RSP_ON_WRITE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [3:0] req_data,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       sync,
  output logic       cm_ram,
  output logic [3:0] dbus_out,
  input  logic [3:0] dbus_in
);

  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  typedef enum logic [1:0] {IDLE, SRC, CMD, RDBK} state_t;

  state_t     state, state_nxt;
  logic [2:0] count, count_nxt;
  logic       pending, pending_nxt;
  logic [3:0] op_q, data_q;
  logic [7:0] addr_q;
  logic       accept, start, write_op, final_nxt;
  logic       cm_nxt, rsp_valid_nxt, ready_nxt;
  logic [3:0] dbus_nxt;

  assign sync     = (count == PH_X3);
  assign accept   = req_valid && req_ready;
  assign start    = pending || accept;
  assign write_op = !op_q[3];

  // Outputs are registered, so each is computed from the state/phase of the coming clock.
  always_comb begin
    count_nxt = count + 3'd1;
    state_nxt = state;
    if (count == PH_X3) begin
      case (state)
        IDLE:    state_nxt = start ? SRC : IDLE;
        SRC:     state_nxt = CMD;
        CMD:     state_nxt = write_op ? (start ? SRC : IDLE) : RDBK;
        RDBK:    state_nxt = start ? SRC : IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    if (count == PH_X3 && state_nxt == SRC)
      pending_nxt = 1'b0;
    else if (accept)
      pending_nxt = 1'b1;
    else
      pending_nxt = pending;

    cm_nxt        = 1'b0;
    dbus_nxt      = 4'h0;
    rsp_valid_nxt = 1'b0;
    case (state_nxt)
      SRC, RDBK: begin
        if (count_nxt == PH_X2) begin
          cm_nxt   = 1'b1;
          dbus_nxt = addr_q[3:0];
        end else if (count_nxt == PH_X3) begin
          dbus_nxt = addr_q[7:4];
        end
        if (state_nxt == RDBK && count_nxt == PH_X3)
          rsp_valid_nxt = 1'b1;
      end
      CMD: begin
        if (count_nxt == PH_M2) begin
          cm_nxt   = 1'b1;
          dbus_nxt = op_q;
        end else if (count_nxt == PH_X2) begin
          dbus_nxt = write_op ? data_q : 4'h0;
        end
        if (count_nxt == PH_X3 && write_op && RSP_ON_WRITE)
          rsp_valid_nxt = 1'b1;
      end
      default: ;
    endcase

    // Ready reopens in the final X3 so a new request can start at the very next A1.
    final_nxt = (state_nxt == RDBK) || (state_nxt == CMD && write_op);
    ready_nxt = !pending_nxt && (state_nxt == IDLE || (count_nxt == PH_X3 && final_nxt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= PH_X3;
      state     <= IDLE;
      pending   <= 1'b0;
      op_q      <= 4'h0;
      addr_q    <= 8'h00;
      data_q    <= 4'h0;
      cm_ram    <= 1'b0;
      dbus_out  <= 4'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= 4'h0;
      req_ready <= 1'b0;
    end else begin
      count     <= count_nxt;
      state     <= state_nxt;
      pending   <= pending_nxt;
      cm_ram    <= cm_nxt;
      dbus_out  <= dbus_nxt;
      rsp_valid <= rsp_valid_nxt;
      req_ready <= ready_nxt;
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        data_q <= req_data;
      end
      if (count == PH_X2 && state == RDBK)
        rsp_data <= dbus_in;
      else if (count == PH_X2 && state == CMD && write_op && RSP_ON_WRITE)
        rsp_data <= 4'h0;
    end
  end

endmodule

// File: tb/tb_mcs4_ram_bus_master.sv
// Directed bench for mcs4_ram_bus_master with a small behavioural i4002 (RAM_ID=1) on the bus.
module tb_mcs4_ram_bus_master;

  localparam logic [1:0] RAM_ID = 2'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = 4'h0;
  logic [7:0] req_addr = 8'h00;
  logic [3:0] req_data = 4'h0;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       sync;
  logic       cm_ram;
  logic [3:0] dbus_out;
  logic [3:0] dbus_in;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mcs4_ram_bus_master #(.RSP_ON_WRITE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .sync(sync), .cm_ram(cm_ram), .dbus_out(dbus_out), .dbus_in(dbus_in)
  );

  // Expected phase of the bus, derived only from reset timing.
  logic [2:0] tb_cnt;
  always @(posedge clk) tb_cnt <= rst ? 3'd7 : tb_cnt + 3'd1;

  // Behavioural i4002: follows sync, latches SRC/opcode, writes at X2, drives reads in the next X2.
  logic [3:0] mem  [4][16];
  logic [3:0] stat [4][4];
  logic [2:0] mcnt;
  logic       sel = 1'b0, src_hi = 1'b0, io_pend = 1'b0, rd_drive = 1'b0;
  logic [1:0] mreg = 2'd0;
  logic [3:0] mchar = 4'h0, mop = 4'h0, rdval;

  always @(posedge clk) begin
    mcnt   <= sync ? 3'd0 : mcnt + 3'd1;
    src_hi <= 1'b0;
    if (rst) begin
      io_pend  <= 1'b0;
      rd_drive <= 1'b0;
      sel      <= 1'b0;
    end else begin
      if (mcnt == 3'd6 && cm_ram) begin
        sel    <= (dbus_out[3:2] == RAM_ID);
        mreg   <= dbus_out[1:0];
        src_hi <= 1'b1;
      end
      if (mcnt == 3'd7 && src_hi) mchar <= dbus_out;
      if (mcnt == 3'd4 && cm_ram && sel) begin
        mop     <= dbus_out;
        io_pend <= 1'b1;
      end
      if (mcnt == 3'd6 && rd_drive) rd_drive <= 1'b0;
      if (mcnt == 3'd6 && io_pend) begin
        io_pend <= 1'b0;
        if (mop[3]) rd_drive <= 1'b1;
        else if (mop == 4'h0) mem[mreg][mchar] <= dbus_out;
        else if (mop[3:2] == 2'b01) stat[mreg][mop[1:0]] <= dbus_out;
      end
    end
  end

  always_comb begin
    rdval = 4'h0;
    if (mop == 4'h8 || mop == 4'h9 || mop == 4'hB) rdval = mem[mreg][mchar];
    else if (mop[3:2] == 2'b11) rdval = stat[mreg][mop[1:0]];
  end

  assign dbus_in = (rd_drive && mcnt == 3'd6) ? rdval : 4'h0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // One transaction; returns in its final X3 so a held req_valid can chain the next one.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] addr, input logic [3:0] data,
                               input logic [3:0] exp_rd, input bit keep_valid, input bit expect_b2b);
    int n, c0, s, kexp, cyc, ph;
    logic       exp_cm;
    logic [3:0] exp_db;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 64) begin
      stepClk();
      n++;
    end
    checkOutput("ready_wait", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    c0 = int'(tb_cnt);
    if (expect_b2b) checkOutput("b2b_phase", c0, 32'd7);
    stepClk();
    if (!keep_valid) req_valid = 1'b0;
    s    = 8 - c0;
    kexp = s + (op[3] ? 23 : 15);
    for (int k = 1; k <= kexp; k++) begin
      exp_cm = 1'b0;
      exp_db = 4'h0;
      if (k >= s) begin
        cyc = (k - s) / 8;
        ph  = (k - s) % 8;
        if (cyc == 0 || cyc == 2) begin
          if (ph == 6) begin
            exp_cm = 1'b1;
            exp_db = addr[3:0];
          end else if (ph == 7) begin
            exp_db = addr[7:4];
          end
        end else if (ph == 4) begin
          exp_cm = 1'b1;
          exp_db = op;
        end else if (ph == 6) begin
          exp_db = op[3] ? 4'h0 : data;
        end
      end
      checkOutput("cm_ram", 32'(cm_ram), 32'(exp_cm));
      checkOutput("dbus_out", 32'(dbus_out), 32'(exp_db));
      checkOutput("sync", 32'(sync), 32'(((c0 + k) % 8) == 7));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(k == kexp));
      checkOutput("req_ready", 32'(req_ready), 32'(k == kexp));
      if (k != kexp) stepClk();
    end
    checkOutput("rsp_data", 32'(rsp_data), 32'(op[3] ? exp_rd : 4'h0));
  endtask

  initial begin
    int n, c0, s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 16; c++) mem[r][c] = 4'h0;
      for (int c = 0; c < 4; c++) stat[r][c] = 4'h0;
    end

    $display("[TB] reset and free-running cycle");
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput("rst_sync", 32'(sync), 32'd1);
      checkOutput("rst_cm_ram", 32'(cm_ram), 32'd0);
      checkOutput("rst_dbus", 32'(dbus_out), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
      checkOutput("rst_ready", 32'(req_ready), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      checkOutput("idle_sync", 32'(sync), 32'((k % 8) == 0));
      checkOutput("idle_cm_ram", 32'(cm_ram), 32'd0);
      checkOutput("idle_dbus", 32'(dbus_out), 32'd0);
      if (k > 0) checkOutput("idle_ready", 32'(req_ready), 32'd1);
      stepClk();
    end

    $display("[TB] RAM and status writes / reads");
    applyStimulus(4'h0, 8'h25, 4'hA, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h9, 8'h25, 4'h0, 4'hA, 1'b0, 1'b0);
    stepClk();
    applyStimulus(4'h6, 8'h07, 4'h5, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'hE, 8'h07, 4'h0, 4'h5, 1'b0, 1'b0);
    applyStimulus(4'h7, 8'h07, 4'h9, 4'h0, 1'b0, 1'b0);
    repeat (3) stepClk();
    applyStimulus(4'hF, 8'h07, 4'h0, 4'h9, 1'b0, 1'b0);

    $display("[TB] unassigned opcodes and absent chip");
    applyStimulus(4'h2, 8'h25, 4'h3, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'hA, 8'h25, 4'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h9, 8'h25, 4'h0, 4'hA, 1'b0, 1'b0);
    applyStimulus(4'h9, 8'h08, 4'h0, 4'h0, 1'b0, 1'b0);
    stepClk();
    checkOutput("chip2_single_pulse", 32'(rsp_valid), 32'd0);

    $display("[TB] back-to-back requests");
    applyStimulus(4'h0, 8'h16, 4'h6, 4'h0, 1'b1, 1'b0);
    applyStimulus(4'h4, 8'h16, 4'h3, 4'h0, 1'b1, 1'b1);
    applyStimulus(4'h9, 8'h16, 4'h0, 4'h6, 1'b0, 1'b1);
    applyStimulus(4'hC, 8'h16, 4'h0, 4'h3, 1'b0, 1'b0);

    $display("[TB] reset during a read command cycle");
    req_op    = 4'h9;
    req_addr  = 8'h25;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 64) begin
      stepClk();
      n++;
    end
    checkOutput("abort_ready_wait", 32'(req_ready), 32'd1);
    c0 = int'(tb_cnt);
    stepClk();
    req_valid = 1'b0;
    s = 8 - c0;
    for (int k = 1; k < s + 13; k++) stepClk();
    checkOutput("abort_in_cmd_x1", 32'(tb_cnt), 32'd5);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput("abort_sync", 32'(sync), 32'd1);
      checkOutput("abort_cm_ram", 32'(cm_ram), 32'd0);
      checkOutput("abort_dbus", 32'(dbus_out), 32'd0);
      checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("abort_rsp_data", 32'(rsp_data), 32'd0);
      checkOutput("abort_ready", 32'(req_ready), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      checkOutput("post_abort_sync", 32'(sync), 32'((k % 8) == 0));
      checkOutput("post_abort_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("post_abort_cm_ram", 32'(cm_ram), 32'd0);
      checkOutput("post_abort_dbus", 32'(dbus_out), 32'd0);
      stepClk();
    end
    applyStimulus(4'h9, 8'h25, 4'h0, 4'hA, 1'b0, 1'b0);
    stepClk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
